// File: rtl/hart_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hart_debug_ctrl
// Brief    : Hart-side debug responder: halt/resume handshake, DPC capture and
//            Access Register commands against the GPR file.
//            Optional feature macro: DEBUG_DPC_ACCESS_EN (regno 0x07B1 -> DPC).
// Revision : 1.0 - initial release
// ============================================================================
module hart_debug_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_req,
    input  logic        resume_req,
    input  logic        exec,
    input  logic [31:0] command,
    input  logic [31:0] data0_in,
    input  logic [31:0] data1_in,
    output logic        halted,
    output logic        done,
    output logic        write,
    output logic        error,
    output logic        exception,
    output logic [31:0] data0_out,
    output logic        core_stall,
    input  logic        core_idle,
    input  logic [31:0] core_pc,
    output logic        resume_valid,
    output logic [31:0] resume_pc,
    output logic [4:0]  gpr_addr,
    output logic        gpr_we,
    output logic [31:0] gpr_wdata,
    input  logic [31:0] gpr_rdata
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        HALTING = 3'd1,
        HALTED  = 3'd2,
        ACCESS  = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_resume_fire;

    logic [31:0] r_cmd;
    logic [31:0] r_dpc;
    logic [31:0] r_data0;
    logic        r_bad_exec;
    logic        r_resume_valid;
    logic        r_write;
    logic        r_error;
    logic        r_exception;
    logic        r_gpr_read;

    logic [15:0] w_regno;
    logic        w_fmt_ok;
    logic        w_transfer;
    logic        w_is_write;
    logic        w_is_gpr;
    logic        w_is_dpc;
    logic        w_acc_ok;
    logic        w_gpr_acc;
    logic        w_dpc_acc;
    logic        w_in_access;
    logic        w_in_resp;
    logic        w_unused_bits;

    // Decode works on the command latched when exec was accepted.
    assign w_regno    = r_cmd[15:0];
    assign w_fmt_ok   = (r_cmd[31:24] == 8'd0) && (r_cmd[22:20] == 3'd2) &&
                        !r_cmd[19] && !r_cmd[18];
    assign w_transfer = r_cmd[17];
    assign w_is_write = r_cmd[16];
    assign w_is_gpr   = (w_regno[15:5] == 11'h080);
`ifdef DEBUG_DPC_ACCESS_EN
    assign w_is_dpc   = (w_regno == 16'h07B1);
`else
    assign w_is_dpc   = 1'b0;
`endif
    assign w_acc_ok   = w_fmt_ok && w_transfer;
    assign w_gpr_acc  = w_acc_ok && w_is_gpr;
    assign w_dpc_acc  = w_acc_ok && w_is_dpc;

    assign w_in_access = (r_state == ACCESS);
    assign w_in_resp   = (r_state == RESP);

    assign w_unused_bits = ^{data1_in, r_cmd[23]};

    always_comb begin
        w_state_next  = r_state;
        w_resume_fire = 1'b0;
        unique case (r_state)
            RUN:     if (halt_req) w_state_next = HALTING;
            HALTING: if (core_idle) w_state_next = HALTED;
            HALTED: begin
                // A pending command takes priority; resume is re-sampled after RESP.
                if (exec) begin
                    w_state_next = ACCESS;
                end else if (resume_req && !halt_req) begin
                    w_state_next  = RUN;
                    w_resume_fire = 1'b1;
                end
            end
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_cmd          <= 32'd0;
            r_dpc          <= RESET_PC;
            r_data0        <= 32'd0;
            r_bad_exec     <= 1'b0;
            r_resume_valid <= 1'b0;
            r_write        <= 1'b0;
            r_error        <= 1'b0;
            r_exception    <= 1'b0;
            r_gpr_read     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_resume_valid <= w_resume_fire;
            r_bad_exec     <= exec && ((r_state == RUN) || (r_state == HALTING));

            if ((r_state == HALTED) && exec) begin
                r_cmd <= command;
            end
            if ((r_state == HALTING) && core_idle) begin
                r_dpc <= core_pc;
            end

            if (w_in_access) begin
                r_error     <= !w_fmt_ok;
                r_exception <= w_acc_ok && !w_is_gpr && !w_is_dpc;
                r_write     <= w_acc_ok && !w_is_write && (w_is_gpr || w_is_dpc);
                r_gpr_read  <= w_gpr_acc && !w_is_write;
                if (w_dpc_acc && !w_is_write) begin
                    r_data0 <= r_dpc;
                end
                if (w_dpc_acc && w_is_write) begin
                    r_dpc <= data0_in;
                end
            end

            if (w_in_resp && r_gpr_read) begin
                r_data0 <= gpr_rdata;
            end
        end
    end

    assign halted       = (r_state == HALTED) || (r_state == ACCESS) || (r_state == RESP);
    assign core_stall   = (r_state != RUN);
    assign resume_valid = r_resume_valid;
    assign resume_pc    = r_dpc;

    assign done      = w_in_resp || r_bad_exec;
    assign write     = w_in_resp && r_write;
    assign error     = (w_in_resp && r_error) || r_bad_exec;
    assign exception = w_in_resp && r_exception;
    // Register-file read data arrives during RESP, so it is forwarded straight out.
    assign data0_out = (w_in_resp && r_gpr_read) ? gpr_rdata : r_data0;

    assign gpr_addr  = (w_in_access && w_gpr_acc) ? w_regno[4:0] : 5'd0;
    assign gpr_we    = w_in_access && w_gpr_acc && w_is_write && (w_regno[4:0] != 5'd0);
    assign gpr_wdata = gpr_we ? data0_in : 32'd0;

endmodule
`default_nettype wire

// File: doc/hart_debug_ctrl.md
# hart_debug_ctrl

Hart-side responder for the debug module interface: receives halt, resume and abstract-command requests from the debug module and returns status, completion and read data. Sits inside the hart next to the pipeline and register file. Stalls the pipeline, records the halt PC (DPC) and executes Access Register commands against the GPR file. On resume, redirects fetch to DPC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, DPC value after reset.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- halt_req  in  1  level from debug module, held until `halted`=1.
- resume_req  in  1  level from debug module, held until `halted`=0.
- exec  in  1  one-cycle pulse; `command` is valid with it.
- command  in  32  abstract command.
- data0_in  in  32  write data for register writes.
- data1_in  in  32  unused; reserved.
- halted  out  1  hart is in debug mode.
- done  out  1  one-cycle command-completion pulse.
- write  out  1  qualifies `done`: `data0_out` must be captured into data0.
- error  out  1  qualifies `done`: command not supported.
- exception  out  1  qualifies `done`: register not accessible.
- data0_out  out  32  read data, valid with `done`&`write`.
- core_stall  out  1  freezes fetch/issue.
- core_idle  in  1  pipeline drained, no instruction in flight.
- core_pc  in  32  PC of next instruction to execute.
- resume_valid  out  1  one-cycle fetch redirect pulse.
- resume_pc  out  32  redirect target (= DPC).
- gpr_addr  out  5  register-file port address.
- gpr_we  out  1  register-file write enable.
- gpr_wdata  out  32  register-file write data.
- gpr_rdata  in  32  read data, one cycle after `gpr_addr`.

## Operation
- States: RUN, HALTING, HALTED, ACCESS, RESP.
- RUN: `halt_req`=1 -> HALTING, `core_stall`=1.
- HALTING: `core_idle`=1 -> HALTED; DPC <= `core_pc`.
- HALTED: `exec` -> ACCESS. Otherwise `resume_req`=1 and `halt_req`=0 -> RUN with `resume_valid` pulse, `resume_pc`=DPC, `core_stall`=0.
- Command decode:
  - [31:24] cmdtype must be 0.
  - [22:20] aarsize must be 2.
  - [19] aarpostincrement must be 0.
  - [18] postexec must be 0.
  - [17] transfer; [16] write; [15:0] regno.
- Any decode field violation -> RESP with `error`=1.
- transfer=0 -> RESP with no flags (no-op).
- regno 0x1000–0x101F -> GPR regno[4:0]:
  - Write: `gpr_we`=1, `gpr_wdata`=`data0_in` for one cycle in ACCESS; writes to x0 are dropped but still succeed.
  - Read: `gpr_addr` is driven in ACCESS; `data0_out` <= `gpr_rdata` in RESP, `write`=1.
- Any other regno -> `exception`=1.
- RESP: `done`=1 for one cycle, then HALTED.
- `exec` outside HALTED -> `done`+`error` pulse the next cycle; state is unchanged.
- Flags are exclusive; all flags are 0 when `done`=0.

## Timing
- Reset values:
  - State RUN; DPC=RESET_PC.
  - `halted`, `done`, `write`, `error`, `exception`, `core_stall`, `resume_valid`, `gpr_we` = 0.
  - `data0_out`, `gpr_addr`, `gpr_wdata` = 0.
- Reset mid-command aborts it with no `done`.
- Halt: `core_stall` is registered the cycle after `halt_req`. `halted` rises the cycle after `core_idle` is sampled high in HALTING. If `core_idle` is already high, `halted` rises 2 cycles after `halt_req`.
- Command: `exec` at cycle N -> ACCESS N+1 -> `done` N+2. Fixed 2-cycle latency for success, error and exception. `exec` during ACCESS/RESP is ignored.
- Resume: `halted`=0 and `resume_valid`=1 one cycle after `resume_req` is sampled in HALTED.
- Conflicts in HALTED:
  - `exec` beats `resume_req`; resume is re-sampled after RESP.
  - `halt_req`=1 blocks resume.

## Configuration
- `DEBUG_DPC_ACCESS_EN` defined: regno 0x07B1 maps to DPC.
  - Read returns DPC with `write`=1.
  - Write sets DPC <= `data0_in`, so the next resume redirects there.
- Undefined: 0x07B1 responds `exception`=1 like any unmapped regno.

## Test plan
- Reset; `halt_req`=1 with `core_idle`=1, `core_pc`=0x80 -> `halted`=1 at cycle 2, `core_stall`=1, DPC=0x80.
- Halted; `exec` with command 0x0023_1005, `data0_in`=0xDEADBEEF -> `gpr_we`, `gpr_addr`=5 at N+1. Then read 0x0022_1005 -> `done`&`write` at N+2, `data0_out`=0xDEADBEEF.
- Halted; command 0x0022_1000 (x0 read) with rdata 0 -> `done`&`write`, `data0_out`=0. Command 0x0102_1000 -> `done`&`error`. Command 0x0022_2000 -> `done`&`exception`.
- `exec` while running -> `done`&`error` at next cycle; `halted` stays 0.
- Halted with DPC=0x80; `exec` and `resume_req` together -> `done` first, then `resume_valid` with `resume_pc`=0x80.
- With `DEBUG_DPC_ACCESS_EN`: write 0x200 to 0x07B1, then resume -> `resume_pc`=0x200. Without it: `done`&`exception`, and resume uses the old DPC.
